adder_arbiter: RTL and testbench
================================

Name: adder_arbiter

Overview:
- Shares one 16-bit carry-look-ahead `Adder` instance (A, B -> rslt, cout) between two requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Grants are round-robin; the adder output is captured in a single response register tagged with its owner.
- Sits between the two requesting datapath units and the shared adder; sustains one add per cycle when consumers are ready.

Parameters:
- WIDTH, 16, operand/result width; fixed to 16 to match the `Adder` instance, other values unsupported.
- PRIO_INIT, 0, requester that wins the first tie after reset (0 or 1).
- CNT_W, 8, width of per-requester grant counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 operands valid.
- req0_ready  output  1  requester 0 operands accepted this cycle.
- req0_a, req0_b  input  16  requester 0 operands.
- req1_valid, req1_ready, req1_a, req1_b  same as above, for requester 1.
- rsp0_valid  output  1  result for requester 0 valid.
- rsp0_ready  input  1  requester 0 consumes result.
- rsp1_valid  output  1  result for requester 1 valid.
- rsp1_ready  input  1  requester 1 consumes result.
- rsp_sum  output  16  registered sum, shared by both response channels.
- rsp_cout  output  1  registered carry-out, shared by both response channels.
- busy  output  1  high when response register is occupied.
- gnt_cnt0, gnt_cnt1  output  CNT_W  accepted-request counts, wrapping.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE; rsp0_valid=rsp1_valid=0; rsp_sum=0; rsp_cout=0; busy=0; gnt_cnt0=gnt_cnt1=0.
  - last-winner pointer = ~PRIO_INIT.
  - reqN_ready forced 0.
- States: IDLE (response register empty), FULL (holding a result for owner o).
- Grant (combinational):
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to the last-winner pointer is granted.
  - Neither valid: no grant.
- Accept window `open` = (state==IDLE) | (state==FULL & rsp_o_ready).
- Readiness: reqN_ready = open & grant==N & reqN_valid. At most one of req0_ready/req1_ready is high per cycle.
- Accept = a req handshake. On accept:
  - Granted operands drive `Adder` A/B combinationally.
  - At the next edge: rsp_sum/rsp_cout <= adder outputs; owner <= N; rspN_valid <= 1, other rsp_valid <= 0; last-winner <= N; gnt_cntN += 1 (wraps modulo 2^CNT_W); state <= FULL.
  - Latency: 1 cycle from accept to rsp valid.
- FULL, no new accept:
  - rsp_o_valid, rsp_sum, rsp_cout held stable until rsp_o_ready.
  - On rsp handshake with no accept that cycle: rsp valids -> 0, state -> IDLE. rsp_sum/rsp_cout keep their last value.
- Simultaneous response handshake and new accept (either requester): back-to-back, no bubble; the register is overwritten with the new result and owner.
- rsp_ready of the non-owner is ignored.
- Operands with reqN_valid=0 never reach the adder result register.
- Arithmetic: sum = (a + b) mod 2^16; cout = bit 16 of the unsigned sum. No carry-in; subtraction is out of scope.
- busy = (state==FULL).
- Reset asserted mid-transaction: the pending result is discarded, all valids drop asynchronously, and the pointer returns to ~PRIO_INIT.

Test Plan:
- Reset release, req0_valid with a=0x1234, b=0x0001 -> req0_ready=1 the same cycle; next cycle rsp0_valid=1, rsp_sum=0x1235, rsp_cout=0, rsp1_valid=0, gnt_cnt0=1.
- Carry out: req1 a=0xFFFF, b=0x0001 -> rsp1_valid=1, rsp_sum=0x0000, rsp_cout=1.
- Both valid continuously, both rsp_ready=1 -> grants alternate 0,1,0,1 with one result per cycle; after 8 cycles gnt_cnt0=gnt_cnt1=4.
- Backpressure:
  - Hold rsp0_ready=0 for 3 cycles after a req0 accept with a=0x00FF, b=0x0F00 -> rsp0_valid, rsp_sum=0x0FFF held stable; req0_ready=req1_ready=0 throughout.
  - Raise rsp0_ready -> a pending req1 is accepted that same cycle.
- Tie after reset with PRIO_INIT=1 -> requester 1 wins the first grant. gnt_cnt with CNT_W=8 after 256 accepts from requester 0 -> wraps to 0.
- Assert rst while state=FULL with rsp0_valid=1 -> rsp0_valid=0, busy=0 immediately, without waiting for a clock edge; after release, a tie grants PRIO_INIT.

Source files
------------

// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end for a single 16-bit carry-look-ahead adder.
// One response register holds the most recent sum, tagged with the requester that owns it.
module adder_arbiter #(
  parameter int WIDTH     = 16,
  parameter int PRIO_INIT = 0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

  // The pointer starts on the requester that should lose the first tie.
  localparam logic LAST_INIT = (PRIO_INIT == 0) ? 1'b1 : 1'b0;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic             rsp_hs;
  logic             open_win;
  logic             gnt_id;
  logic             accept;
  logic [15:0]      add_a, add_b, add_rslt;
  logic             add_cout;

  // Shared 16-bit carry-look-ahead adder: four 4-bit groups plus a group-level lookahead.
  logic [15:0] g, p, cbit;
  logic [3:0]  grp_g, grp_p;
  logic [4:0]  gc;
  logic        cin;

  assign cin   = 1'b0;
  assign g     = add_a & add_b;
  assign p     = add_a ^ add_b;
  assign gc[0] = cin;
  assign gc[1] = grp_g[0] | (grp_p[0] & cin);
  assign gc[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
  assign gc[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
               | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
  assign gc[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cla
      localparam int B = 4 * gi;
      assign grp_g[gi]  = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                        | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign grp_p[gi]  = &p[B+3:B];
      assign cbit[B]    = gc[gi];
      assign cbit[B+1]  = g[B] | (p[B] & gc[gi]);
      assign cbit[B+2]  = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[gi]);
      assign cbit[B+3]  = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                        | (p[B+2] & p[B+1] & p[B] & gc[gi]);
    end
  endgenerate

  assign add_rslt = p ^ cbit;
  assign add_cout = gc[4];

  // Grant, accept window and operand steering.
  always_comb begin
    rsp_hs   = (state_q == FULL) & (owner_q ? rsp1_ready : rsp0_ready);
    open_win = ~rst & ((state_q == IDLE) | rsp_hs);
    gnt_id   = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    accept   = open_win & (req0_valid | req1_valid);
    add_a    = '0;
    add_b    = '0;
    if (accept) begin
      add_a = gnt_id ? req1_a : req0_a;
      add_b = gnt_id ? req1_b : req0_b;
    end
  end

  assign req0_ready = accept & ~gnt_id;
  assign req1_ready = accept & gnt_id;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    if (accept) begin
      state_d = FULL;
      owner_d = gnt_id;
      last_d  = gnt_id;
      sum_d   = add_rslt;
      cout_d  = add_cout;
      if (gnt_id) cnt1_d = cnt1_q + CNT_W'(1);
      else        cnt0_d = cnt0_q + CNT_W'(1);
    end else if (rsp_hs) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= LAST_INIT;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign rsp0_valid = (state_q == FULL) & ~owner_q;
  assign rsp1_valid = (state_q == FULL) & owner_q;
  assign rsp_sum    = sum_q;
  assign rsp_cout   = cout_q;
  assign busy       = (state_q == FULL);
  assign gnt_cnt0   = cnt0_q;
  assign gnt_cnt1   = cnt1_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter; a second instance with PRIO_INIT=1 checks the first tie.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_cout, busy;
  logic [15:0] rsp_sum;
  logic [7:0]  gnt_cnt0, gnt_cnt1;

  logic        d1_req0_ready, d1_req1_ready, d1_rsp0_valid, d1_rsp1_valid, d1_rsp_cout, d1_busy;
  logic [15:0] d1_rsp_sum;
  logic [7:0]  d1_gnt_cnt0, d1_gnt_cnt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.WIDTH(16), .PRIO_INIT(0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  adder_arbiter #(.WIDTH(16), .PRIO_INIT(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(d1_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(d1_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(d1_rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(d1_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_sum(d1_rsp_sum), .rsp_cout(d1_rsp_cout), .busy(d1_busy),
    .gnt_cnt0(d1_gnt_cnt0), .gnt_cnt1(d1_gnt_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, with a request already pending.
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0001;
    #2;
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sum", {16'd0, rsp_sum}, 32'd0);
    check("rst_cnt0", {24'd0, gnt_cnt0}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("t1_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("t1_req1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    check("t1_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("t1_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("t1_sum", {16'd0, rsp_sum}, 32'h1235);
    check("t1_cout", {31'd0, rsp_cout}, 32'd0);
    check("t1_cnt0", {24'd0, gnt_cnt0}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);

    // Carry out from requester 1, accepted as requester 0 drains.
    req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'h0001;
    #1;
    check("t2_req1_ready", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    check("t2_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    check("t2_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("t2_sum", {16'd0, rsp_sum}, 32'h0000);
    check("t2_cout", {31'd0, rsp_cout}, 32'd1);
    check("t2_cnt1", {24'd0, gnt_cnt1}, 32'd1);

    // Drain to IDLE; the result register keeps its last value.
    tick();
    check("t3_busy", {31'd0, busy}, 32'd0);
    check("t3_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("t3_cout_kept", {31'd0, rsp_cout}, 32'd1);

    // Both requesters continuously valid: strict alternation starting with 0.
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req0_a = 16'h0100 + 16'(k); req0_b = 16'h0010;
      req1_a = 16'h0200 + 16'(k); req1_b = 16'h0020;
      #1;
      check($sformatf("alt%0d_req0_ready", k), {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      tick();
      check($sformatf("alt%0d_rsp1_valid", k), {31'd0, rsp1_valid}, (k % 2 == 1) ? 32'd1 : 32'd0);
      check($sformatf("alt%0d_sum", k), {16'd0, rsp_sum},
            (k % 2 == 0) ? (32'h0110 + 32'(k)) : (32'h0220 + 32'(k)));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("alt_cnt0", {24'd0, gnt_cnt0}, 32'd5);
    check("alt_cnt1", {24'd0, gnt_cnt1}, 32'd5);
    tick();
    check("alt_drain_busy", {31'd0, busy}, 32'd0);

    // Backpressure on requester 0 while requester 1 waits.
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h00FF; req0_b = 16'h0F00;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h0003; req1_b = 16'h0004;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d_rsp0_valid", k), {31'd0, rsp0_valid}, 32'd1);
      check($sformatf("bp%0d_sum", k), {16'd0, rsp_sum}, 32'h0FFF);
      check($sformatf("bp%0d_req0_ready", k), {31'd0, req0_ready}, 32'd0);
      check($sformatf("bp%0d_req1_ready", k), {31'd0, req1_ready}, 32'd0);
      tick();
    end
    rsp0_ready = 1'b1;
    #1;
    check("bp_release_req1_ready", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    check("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    check("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("bp_sum", {16'd0, rsp_sum}, 32'h0007);
    check("bp_cnt1", {24'd0, gnt_cnt1}, 32'd6);
    tick();

    // Reset asserted while holding a result drops everything without a clock edge.
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h0005; req0_b = 16'h0006;
    tick();
    req0_valid = 1'b0;
    check("mr_rsp0_valid_before", {31'd0, rsp0_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mr_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_cnt0", {24'd0, gnt_cnt0}, 32'd0);
    check("mr_sum", {16'd0, rsp_sum}, 32'd0);
    tick();
    rst = 1'b0;

    // First tie after reset: PRIO_INIT decides the winner.
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222;
    req1_valid = 1'b1; req1_a = 16'h4444; req1_b = 16'h0004;
    #1;
    check("tie_p0_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("tie_p0_req1_ready", {31'd0, req1_ready}, 32'd0);
    check("tie_p1_req1_ready", {31'd0, d1_req1_ready}, 32'd1);
    check("tie_p1_req0_ready", {31'd0, d1_req0_ready}, 32'd0);
    tick();
    check("tie_p0_sum", {16'd0, rsp_sum}, 32'h3333);
    check("tie_p1_sum", {16'd0, d1_rsp_sum}, 32'h4448);
    check("tie_p1_rsp1_valid", {31'd0, d1_rsp1_valid}, 32'd1);
    check("tie_p1_cnt1", {24'd0, d1_gnt_cnt1}, 32'd1);

    // 256 back-to-back accepts from requester 0 wrap its counter.
    req1_valid = 1'b0;
    req0_a = 16'h8000; req0_b = 16'h8000;
    repeat (255) tick();
    req0_valid = 1'b0;
    check("wrap_cnt0", {24'd0, gnt_cnt0}, 32'd0);
    check("wrap_cnt1", {24'd0, gnt_cnt1}, 32'd0);
    check("wrap_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("wrap_sum", {16'd0, rsp_sum}, 32'h0000);
    check("wrap_cout", {31'd0, rsp_cout}, 32'd1);
    tick();
    check("end_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
